// File: rtl/pwc_frame_rx.sv
// Pulse-width-coded serial frame receiver: short low pulse = 1, long low pulse = 0.
// Frames are ADDR_W+DATA_W bits, LSB first; matching frames latch their data field onto led.
module pwc_frame_rx #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 3,
   parameter int unsigned THRESH   = 8,
   parameter int unsigned MAX_LOW  = 15,
   parameter int unsigned IDLE_TO  = 31,
   parameter bit          BCAST_EN = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rxd,
   input  logic [ADDR_W-1:0] ref_addr,   // station address
   output logic [DATA_W-1:0] led,
   output logic              frame_done,
   output logic              addr_hit,
   output logic              frame_err
);

   localparam int unsigned N       = ADDR_W + DATA_W;
   localparam int unsigned CNT_MAX = (MAX_LOW > IDLE_TO) ? MAX_LOW : IDLE_TO;
   localparam int unsigned CW      = $clog2(CNT_MAX + 2);
   localparam int unsigned BW      = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, LOW, GAP, DONE, ERR} state_t;

   state_t            state, state_d;
   logic [CW-1:0]     lcnt, lcnt_d, gcnt, gcnt_d;
   logic [BW-1:0]     bitcnt, bitcnt_d;
   logic [N-1:0]      shreg, shreg_d;
   logic [DATA_W-1:0] led_d;
   logic              done_d, hit_d, err_d;
   logic [ADDR_W-1:0] addr_c;
   logic              match_c;
   logic [CW-1:0]     lcnt_inc_c, gcnt_inc_c;

   assign addr_c     = shreg[N-1:DATA_W];
   assign match_c    = (addr_c == ref_addr) || (BCAST_EN && (&addr_c));
   assign lcnt_inc_c = lcnt + CW'(1);
   assign gcnt_inc_c = gcnt + CW'(1);

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         lcnt       <= '0;
         gcnt       <= '0;
         bitcnt     <= '0;
         shreg      <= '0;
         led        <= '0;
         frame_done <= 1'b0;
         addr_hit   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_d;
         lcnt       <= lcnt_d;
         gcnt       <= gcnt_d;
         bitcnt     <= bitcnt_d;
         shreg      <= shreg_d;
         led        <= led_d;
         frame_done <= done_d;
         addr_hit   <= hit_d;
         frame_err  <= err_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state;
      lcnt_d   = lcnt;
      gcnt_d   = gcnt;
      bitcnt_d = bitcnt;
      shreg_d  = shreg;
      led_d    = led;
      done_d   = 1'b0;
      hit_d    = 1'b0;
      err_d    = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd) begin
               state_d = LOW;
               lcnt_d  = CW'(1);
            end
         end
         LOW: begin
            if (!rxd) begin
               lcnt_d = lcnt_inc_c;
               if (lcnt_inc_c > CW'(MAX_LOW)) begin
                  state_d  = ERR;
                  err_d    = 1'b1;
                  bitcnt_d = '0;
               end
            end else begin
               // Pulse ended: classify and shift in from the MSB side
               shreg_d  = {(lcnt < CW'(THRESH)), shreg[N-1:1]};
               bitcnt_d = bitcnt + BW'(1);
               gcnt_d   = CW'(1);
               state_d  = (bitcnt == BW'(N-1)) ? DONE : GAP;
            end
         end
         GAP: begin
            if (rxd) begin
               gcnt_d = gcnt_inc_c;
               if (gcnt_inc_c > CW'(IDLE_TO)) begin
                  state_d  = ERR;
                  err_d    = 1'b1;
                  bitcnt_d = '0;
               end
            end else begin
               state_d = LOW;
               lcnt_d  = CW'(1);
            end
         end
         DONE: begin
            done_d   = 1'b1;
            hit_d    = match_c;
            bitcnt_d = '0;
            if (match_c) led_d = shreg[DATA_W-1:0];
            if (!rxd) begin
               state_d = LOW;
               lcnt_d  = CW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         ERR: begin
            if (rxd) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pwc_frame_rx.sv
// Directed bench for pwc_frame_rx: table of whole frames plus hand-written corner sequences.
// A second instance with broadcast disabled shares the serial line.
module tb_pwc_frame_rx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rxd   = 1'b1;
   logic [4:0] ref_addr = '0;
   logic [2:0] led, led_nb;
   logic       frame_done, addr_hit, frame_err;
   logic       frame_done_nb, addr_hit_nb, frame_err_nb;

   int total = 0;
   int bad   = 0;
   int err_cnt = 0;

   pwc_frame_rx dut (
      .clock(clock), .reset(reset), .rxd(rxd), .ref_addr(ref_addr),
      .led(led), .frame_done(frame_done), .addr_hit(addr_hit), .frame_err(frame_err)
   );

   pwc_frame_rx #(.BCAST_EN(1'b0)) dut_nb (
      .clock(clock), .reset(reset), .rxd(rxd), .ref_addr(ref_addr),
      .led(led_nb), .frame_done(frame_done_nb), .addr_hit(addr_hit_nb), .frame_err(frame_err_nb)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (frame_err) err_cnt <= err_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   typedef struct {
      logic [4:0] ref_v;
      logic [7:0] frame;
      int         l1;
      int         l0;
      logic       hit;
      logic [2:0] led;
      logic       hit_nb;
      logic [2:0] led_nb;
   } vec_t;

   vec_t tbl[6];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic pulse(input int len);
      rxd = 1'b0;
      repeat (len) tick();
      rxd = 1'b1;
   endtask

   // Sends one frame; returns frame_done as seen right after the classify edge and
   // leaves time just after the DONE edge. pre = low edges of bit 0 already elapsed.
   task automatic send_frame(input logic [7:0] f, input int l1, input int l0,
                             input int pre, input bit b2b, output logic pre_done);
      int len;
      for (int i = 0; i < 8; i++) begin
         len = f[i] ? l1 : l0;
         if (i == 0) len -= pre;
         rxd = 1'b0;
         repeat (len) tick();
         rxd = 1'b1;
         if (i < 7) repeat (2) tick();
      end
      tick();
      pre_done = frame_done;
      if (b2b) rxd = 1'b0;
      tick();
   endtask

   task automatic frame_ok(input string name, input logic [7:0] f, input logic [2:0] exp_led);
      logic pd;
      send_frame(f, 3, 10, 0, 1'b0, pd);
      chk({name, "_pre_done"}, pd, 0);
      chk({name, "_done"}, frame_done, 1);
      chk({name, "_hit"}, addr_hit, 1);
      chk({name, "_led"}, led, exp_led);
      tick();
      chk({name, "_done_end"}, frame_done, 0);
   endtask

   initial begin
      logic pd;
      int   e0;

      tbl[0] = '{5'b10110, 8'b10110_101, 3, 10, 1'b1, 3'b101, 1'b1, 3'b101};
      tbl[1] = '{5'b10110, 8'b11111_111, 7, 10, 1'b1, 3'b111, 1'b0, 3'b101};
      tbl[2] = '{5'b00001, 8'b00000_000, 3,  8, 1'b0, 3'b111, 1'b0, 3'b101};
      tbl[3] = '{5'b00000, 8'b00000_000, 3, 15, 1'b1, 3'b000, 1'b1, 3'b000};
      tbl[4] = '{5'b00001, 8'b00010_111, 3, 10, 1'b0, 3'b000, 1'b0, 3'b000};
      tbl[5] = '{5'b00001, 8'b11111_110, 3, 10, 1'b1, 3'b110, 1'b0, 3'b000};

      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("rst_led", led, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_hit", addr_hit, 0);
      chk("rst_err", frame_err, 0);

      for (int v = 0; v < 6; v++) begin
         ref_addr = tbl[v].ref_v;
         send_frame(tbl[v].frame, tbl[v].l1, tbl[v].l0, 0, 1'b0, pd);
         chk($sformatf("v%0d_pre_done", v), pd, 0);
         chk($sformatf("v%0d_done", v), frame_done, 1);
         chk($sformatf("v%0d_hit", v), addr_hit, tbl[v].hit);
         chk($sformatf("v%0d_led", v), led, tbl[v].led);
         chk($sformatf("v%0d_done_nb", v), frame_done_nb, 1);
         chk($sformatf("v%0d_hit_nb", v), addr_hit_nb, tbl[v].hit_nb);
         chk($sformatf("v%0d_led_nb", v), led_nb, tbl[v].led_nb);
         tick();
         chk($sformatf("v%0d_done_end", v), frame_done, 0);
      end
      chk("table_no_err", err_cnt, 0);

      // Over-long pulse after three bits
      ref_addr = 5'b10110;
      e0 = err_cnt;
      for (int k = 0; k < 3; k++) begin pulse(3); repeat (2) tick(); end
      rxd = 1'b0;
      repeat (15) tick();
      chk("long_l15_err", frame_err, 0);
      tick();
      chk("long_l16_err", frame_err, 1);
      tick();
      chk("long_err_once", frame_err, 0);
      repeat (20) tick();
      chk("long_no_done", frame_done, 0);
      rxd = 1'b1;
      repeat (3) tick();
      chk("long_err_cnt", err_cnt - e0, 1);
      frame_ok("after_long", 8'b10110_010, 3'b010);

      // Gap timeout after four bits
      e0 = err_cnt;
      for (int k = 0; k < 3; k++) begin pulse(3); repeat (2) tick(); end
      pulse(10);
      repeat (31) tick();
      chk("gap_31_err", frame_err, 0);
      tick();
      chk("gap_32_err", frame_err, 1);
      tick();
      chk("gap_err_once", frame_err, 0);
      chk("gap_err_cnt", err_cnt - e0, 1);
      frame_ok("after_gap", 8'b10110_001, 3'b001);

      // Back-to-back: second frame starts low in the DONE cycle, bit 0 is a boundary 0 (L=8)
      e0 = err_cnt;
      send_frame(8'b10110_011, 3, 10, 0, 1'b1, pd);
      chk("b2b1_pre_done", pd, 0);
      chk("b2b1_done", frame_done, 1);
      chk("b2b1_led", led, 3'b011);
      send_frame(8'b10110_100, 3, 8, 1, 1'b0, pd);
      chk("b2b2_pre_done", pd, 0);
      chk("b2b2_done", frame_done, 1);
      chk("b2b2_hit", addr_hit, 1);
      chk("b2b2_led", led, 3'b100);
      chk("b2b_no_err", err_cnt - e0, 0);
      tick();

      // Reset in the middle of a frame
      e0 = err_cnt;
      for (int k = 0; k < 5; k++) begin pulse(3); repeat (2) tick(); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_led", led, 0);
      chk("mid_rst_led_nb", led_nb, 0);
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_hit", addr_hit, 0);
      chk("mid_rst_err", frame_err, 0);
      repeat (40) tick();
      chk("mid_rst_no_err", err_cnt - e0, 0);
      frame_ok("after_rst", 8'b10110_110, 3'b110);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
